stratix_tx_serializer_mc: RTL and testbench

Multi-channel, parametrised transmit serializer for the Stratix-family LVDS emulation models.
- Accepts one parallel word per channel through a valid/ready handshake and holds it in a one-deep holding register.
- Generates its own load strobe from a bit counter, so no external load-enable alignment is needed. Serialises all lanes in lockstep.
- Drives a matching frame clock (tx_outclock). Substitutes an idle word and flags underflow when no data is ready at a word boundary.

---
 rtl/stratix_tx_ser_pkg.sv | 9 +
 rtl/stratix_tx_ser_lane.sv | 29 ++
 rtl/stratix_tx_serializer_mc.sv | 81 ++++++++
 tb/tb_stratix_tx_serializer_mc.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/stratix_tx_ser_pkg.sv
// stratix_tx_ser_pkg: shared constants, bit-order type and counter sizing for the tx serializer
package stratix_tx_ser_pkg;
    localparam int MAX_DESER_FACTOR = 10;
    localparam int MAX_CHANNELS = 16;
    typedef enum logic {LSB_FIRST_E = 1'b0, MSB_FIRST_E = 1'b1} bit_order_e;
    function automatic int cnt_width(input int f);
        return (f < 2) ? 1 : $clog2(f);
    endfunction
endpackage

// File: rtl/stratix_tx_ser_lane.sv
// stratix_tx_ser_lane: one serial lane with load mux, shift register and negedge retime stage
module stratix_tx_ser_lane
    import stratix_tx_ser_pkg::*;
#(
    parameter int F = 4,
    parameter bit_order_e ORDER = MSB_FIRST_E,
    parameter logic [F-1:0] IDLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic         word_valid,
    input  logic [F-1:0] word,
    output logic         ser,
    output logic         ser_neg
);
    logic [F-1:0] sh;
    always_ff @(posedge clk) begin
        if (!rst_n) sh <= '0;
        else if (load) sh <= word_valid ? word : IDLE;
        else if (en) sh <= (ORDER == MSB_FIRST_E) ? sh << 1 : sh >> 1;
    end
    assign ser = (ORDER == MSB_FIRST_E) ? sh[F-1] : sh[0];
    always_ff @(negedge clk) begin
        if (!rst_n) ser_neg <= 1'b0;
        else ser_neg <= ser;
    end
endmodule

// File: rtl/stratix_tx_serializer_mc.sv
// stratix_tx_serializer_mc: multi-lane transmit serializer with self-timed load, handshake and frame clock
module stratix_tx_serializer_mc
    import stratix_tx_ser_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int DESER_FACTOR = 4,
    parameter string BYPASS_SERIALIZER = "FALSE",
    parameter string INVERT_CLOCK = "FALSE",
    parameter string USE_FALLING_CLOCK_EDGE = "FALSE",
    parameter int MSB_FIRST = 1,
    parameter logic [DESER_FACTOR-1:0] IDLE_WORD = '0
) (
    input  logic                                 tx_fastclk,
    input  logic                                 tx_rst_n,
    input  logic                                 tx_enable,
    input  logic [NUM_CHANNELS*DESER_FACTOR-1:0] tx_in,
    input  logic                                 tx_in_valid,
    output logic                                 tx_in_ready,
    input  logic                                 err_clr,
    output logic [NUM_CHANNELS-1:0]              tx_out,
    output logic                                 tx_outclock,
    output logic                                 tx_load,
    output logic                                 underflow_err
);
    localparam int CW = cnt_width(DESER_FACTOR);
    localparam logic [CW-1:0] LAST = CW'(DESER_FACTOR - 1);
    localparam logic [CW-1:0] HALF = CW'((DESER_FACTOR + 1) / 2);
    localparam bit BYP = BYPASS_SERIALIZER == "TRUE";
    localparam bit INV = INVERT_CLOCK == "TRUE";
    localparam bit FALL = USE_FALLING_CLOCK_EDGE == "TRUE";
    localparam bit_order_e ORDER = bit_order_e'(MSB_FIRST != 0);
    logic en_s1, en_q, hold_valid, accept, frame, frame_neg, fast;
    logic [CW-1:0] cnt;
    logic [NUM_CHANNELS*DESER_FACTOR-1:0] hold;
    logic [NUM_CHANNELS-1:0] ser, ser_neg;
    assign tx_load = en_q && cnt == LAST;
    assign tx_in_ready = !hold_valid || tx_load;
    assign accept = tx_in_valid && tx_in_ready;
    assign frame = en_q && cnt < HALF;
    always_ff @(posedge tx_fastclk) begin
        if (!tx_rst_n) begin
            en_s1 <= 1'b0;
            en_q <= 1'b0;
            cnt <= '0;
            hold_valid <= 1'b0;
            hold <= '0;
            underflow_err <= 1'b0;
        end else begin
            en_s1 <= tx_enable;
            en_q <= en_s1;
            cnt <= (!en_q || tx_load) ? '0 : cnt + 1'b1;
            hold_valid <= accept || (hold_valid && !tx_load);
            if (accept) hold <= tx_in;
            underflow_err <= (tx_load && !hold_valid) || (underflow_err && !err_clr);
        end
    end
    always_ff @(negedge tx_fastclk) begin
        if (!tx_rst_n) frame_neg <= 1'b0;
        else frame_neg <= frame;
    end
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        stratix_tx_ser_lane #(
            .F(DESER_FACTOR),
            .ORDER(ORDER),
            .IDLE(IDLE_WORD)
        ) u_lane (
            .clk(tx_fastclk),
            .rst_n(tx_rst_n),
            .en(en_q),
            .load(tx_load),
            .word_valid(hold_valid),
            .word(hold[c*DESER_FACTOR +: DESER_FACTOR]),
            .ser(ser[c]),
            .ser_neg(ser_neg[c])
        );
    end
    // bypass forwards the fast clock itself on every output
    assign fast = INV ? ~tx_fastclk : tx_fastclk;
    assign tx_outclock = BYP ? fast : FALL ? frame_neg : frame;
    assign tx_out = BYP ? {NUM_CHANNELS{fast}} : FALL ? ser_neg : ser;
endmodule

// File: tb/tb_stratix_tx_serializer_mc.sv
// tb_stratix_tx_serializer_mc: scoreboard bench for the default serializer plus mode-variant instances
module tb_stratix_tx_serializer_mc;
    localparam int N = 4;
    localparam int F = 4;
    logic clk = 1'b0;
    logic rst_n, en, valid, err_clr;
    logic [N*F-1:0] tx_in;
    logic tx_in_ready, tx_outclock, tx_load, uf_err;
    logic [N-1:0] tx_out;
    logic f_ready, f_oc, f_load, f_err;
    logic [N-1:0] f_out;
    logic s_ready, s_oc, s_load, s_err;
    logic [0:0] s_out;
    logic o_ready, o_oc, o_load, o_err;
    logic [1:0] o_out;
    logic b_ready, b_oc, b_load, b_err;
    logic [1:0] b_out;
    int n_cmp = 0;
    int n_bad = 0;
    logic [N:0] bitq[$];
    logic [N*F-1:0] wordq[$];
    logic [N:0] last_e;
    logic last_v = 1'b0;
    int n;
    logic [6:0] exp7 = 7'h5A;

    always #5 clk = ~clk;

    stratix_tx_serializer_mc u_main (
        .tx_fastclk(clk), .tx_rst_n(rst_n), .tx_enable(en), .tx_in(tx_in), .tx_in_valid(valid),
        .tx_in_ready(tx_in_ready), .err_clr(err_clr), .tx_out(tx_out), .tx_outclock(tx_outclock),
        .tx_load(tx_load), .underflow_err(uf_err)
    );
    stratix_tx_serializer_mc #(.USE_FALLING_CLOCK_EDGE("TRUE")) u_fall (
        .tx_fastclk(clk), .tx_rst_n(rst_n), .tx_enable(en), .tx_in(tx_in), .tx_in_valid(valid),
        .tx_in_ready(f_ready), .err_clr(err_clr), .tx_out(f_out), .tx_outclock(f_oc),
        .tx_load(f_load), .underflow_err(f_err)
    );
    stratix_tx_serializer_mc #(.NUM_CHANNELS(1), .DESER_FACTOR(7), .MSB_FIRST(0)) u_f7 (
        .tx_fastclk(clk), .tx_rst_n(rst_n), .tx_enable(en), .tx_in(7'h5A), .tx_in_valid(1'b1),
        .tx_in_ready(s_ready), .err_clr(1'b0), .tx_out(s_out), .tx_outclock(s_oc),
        .tx_load(s_load), .underflow_err(s_err)
    );
    stratix_tx_serializer_mc #(.NUM_CHANNELS(2), .DESER_FACTOR(1)) u_f1 (
        .tx_fastclk(clk), .tx_rst_n(rst_n), .tx_enable(en), .tx_in(2'b10), .tx_in_valid(1'b1),
        .tx_in_ready(o_ready), .err_clr(1'b0), .tx_out(o_out), .tx_outclock(o_oc),
        .tx_load(o_load), .underflow_err(o_err)
    );
    stratix_tx_serializer_mc #(.NUM_CHANNELS(2), .BYPASS_SERIALIZER("TRUE"), .INVERT_CLOCK("TRUE")) u_byp (
        .tx_fastclk(clk), .tx_rst_n(rst_n), .tx_enable(en), .tx_in(8'h00), .tx_in_valid(1'b0),
        .tx_in_ready(b_ready), .err_clr(1'b0), .tx_out(b_out), .tx_outclock(b_oc),
        .tx_load(b_load), .underflow_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // compare the current serial bit, schedule the next word on a load, record accepted words
    task automatic monitor();
        logic [N:0] e;
        logic [N*F-1:0] w;
        last_v = 1'b0;
        if (bitq.size() > 0) begin
            e = bitq.pop_front();
            chk("lane_bits", tx_out, e[N-1:0]);
            chk("outclock", tx_outclock, e[N]);
            last_e = e;
            last_v = 1'b1;
        end
        if (tx_load) begin
            w = '0;
            if (wordq.size() > 0) w = wordq.pop_front();
            for (int i = 0; i < F; i++) begin
                for (int c = 0; c < N; c++) e[c] = w[c*F + F-1-i];
                e[N] = (i < (F + 1) / 2);
                bitq.push_back(e);
            end
        end
        if (valid && tx_in_ready) wordq.push_back(tx_in);
    endtask

    task automatic tick();
        monitor();
        @(posedge clk);
        #1;
        if (last_v) begin
            chk("fall_lanes", f_out, last_e[N-1:0]);
            chk("fall_outclock", f_oc, last_e[N]);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic wait_load(output int cnt);
        cnt = 0;
        while (!tx_load && cnt < 100) begin
            tick();
            cnt++;
        end
    endtask

    task automatic send(input logic [N*F-1:0] w);
        int g = 0;
        tx_in = w;
        valid = 1'b1;
        while (!tx_in_ready && g < 50) begin
            tick();
            g++;
        end
        chk("send_wait", g < 50, 1);
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        valid = 1'b0;
        err_clr = 1'b0;
        tx_in = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("byp_low_lanes", b_out, 2'b11);
        chk("byp_low_oc", b_oc, 1);
        @(posedge clk);
        #2;
        chk("byp_high_lanes", b_out, 2'b00);
        chk("byp_high_oc", b_oc, 0);
        @(negedge clk);
        #1;
        chk("rst_out", tx_out, 0);
        chk("rst_oc", tx_outclock, 0);
        chk("rst_load", tx_load, 0);
        chk("rst_ready", tx_in_ready, 1);
        chk("rst_err", uf_err, 0);
        chk("rst_fall_out", f_out, 0);
        rst_n = 1'b1;
        en = 1'b1;
        tx_in = {4'hF, 4'h9, 4'h6, 4'hA};
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_load(n);
        chk("first_load_latency", n + 1, 5);
        send(16'h3333);
        send(16'hCCCC);
        send(16'h5555);
        repeat (6) tick();
        chk("b2b_no_underflow", uf_err, 0);
        repeat (4) tick();
        chk("underflow_set", uf_err, 1);
        n = 0;
        while (tx_load && n < 10) begin
            tick();
            n++;
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", uf_err, 0);
        wait_load(n);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("set_beats_clr", uf_err, 1);
        n = 0;
        while (!s_load && n < 20) begin
            tick();
            n++;
        end
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("f7_bit", s_out, exp7[i]);
            chk("f7_outclock", s_oc, i < 4);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("f1_load", o_load, 1);
            chk("f1_out", o_out, 2'b10);
            tick();
        end
        send(16'hA5A5);
        wait_load(n);
        tick();
        send(16'h0F0F);
        rst_n = 1'b0;
        bitq.delete();
        wordq.delete();
        tick();
        chk("midrst_out", tx_out, 0);
        chk("midrst_oc", tx_outclock, 0);
        chk("midrst_load", tx_load, 0);
        chk("midrst_ready", tx_in_ready, 1);
        chk("midrst_err", uf_err, 0);
        rst_n = 1'b1;
        tick();
        wait_load(n);
        chk("restart_latency", n + 1, 5);
        tick();
        chk("hold_discarded", uf_err, 1);
        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
